// File: rtl/tt_um_s_grundner.sv
// tt_um_s_grundner: 8-bit accumulator ALU driven by an execute strobe.
//
// Each rising edge of the strobe uio_in[3] runs one operation. The operation
// combines the accumulator with operand B and writes the result back to the
// accumulator, along with the carry and overflow flags.
//
// Ports:
//   clk     - single clock; all state updates on its rising edge
//   rst_n   - synchronous reset, active HIGH despite the name
//   ena     - enable; when low every register holds
//   ui_in   - operand B
//   uio_in  - [2:0] opcode, [3] execute strobe, [7:4] ignored
//   uo_out  - accumulator ACC
//   uio_out - [7] V, [6] N, [5] C, [4] Z, [3:0] zero
//   uio_oe  - constant 8'hF0: upper nibble driven, lower nibble input
//
// Opcodes: 000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR,
//          110 SHL, 111 SHR (logical)
module tt_um_s_grundner (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b111;

  localparam logic [DATA_W-1:0] OE_MASK = 8'hF0;

  // Architectural state
  logic [DATA_W-1:0] acc_q;
  logic              c_q;
  logic              v_q;
  logic              ps_q;

  // Z and N are kept in registers that load from the next accumulator
  // value. They always equal (acc_q == 0) and acc_q[7], and no input
  // reaches the pins through logic.
  logic              z_q;
  logic              n_q;

  // Decoded inputs
  logic [OP_W-1:0]   opcode;
  logic              strobe;
  logic [DATA_W-1:0] operand_b;
  logic              exec;

  // ALU datapath
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;

  // Values to be registered
  logic [DATA_W-1:0] acc_d;
  logic              c_d;
  logic              v_d;

  // Split the uio_in fields; bits [7:4] are deliberately unused
  always_comb begin
    opcode    = uio_in[OP_W-1:0];
    strobe    = uio_in[3];
    operand_b = ui_in;
  end

  // Rising-edge detect on the strobe, blocked during reset and when disabled
  always_comb begin
    exec = ena & ~rst_n & strobe & ~ps_q;
  end

  // 9-bit add/subtract; bit 8 gives the carry, or the borrow for SUB
  always_comb begin
    sum_ext  = {1'b0, acc_q} + {1'b0, operand_b};
    diff_ext = {1'b0, acc_q} - {1'b0, operand_b};
  end

  // Result and flag selection by opcode
  always_comb begin
    alu_res = acc_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_LOAD: begin
        alu_res = operand_b;
      end
      OP_ADD: begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        // Overflow: both operands have the same sign, and the result sign differs
        alu_v   = (acc_q[DATA_W-1] == operand_b[DATA_W-1]) &&
                  (sum_ext[DATA_W-1] != acc_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[DATA_W-1:0];
        alu_c   = diff_ext[DATA_W];
        // Overflow: the operand signs differ, and the result sign differs from ACC
        alu_v   = (acc_q[DATA_W-1] != operand_b[DATA_W-1]) &&
                  (diff_ext[DATA_W-1] != acc_q[DATA_W-1]);
      end
      OP_AND: begin
        alu_res = acc_q & operand_b;
      end
      OP_OR: begin
        alu_res = acc_q | operand_b;
      end
      OP_XOR: begin
        alu_res = acc_q ^ operand_b;
      end
      OP_SHL: begin
        alu_res = {acc_q[DATA_W-2:0], 1'b0};
        alu_c   = acc_q[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, acc_q[DATA_W-1:1]};
        alu_c   = acc_q[0];
      end
      default: begin
        alu_res = acc_q;
      end
    endcase
  end

  // Commit the ALU result only on an execute edge; otherwise hold
  always_comb begin
    acc_d = acc_q;
    c_d   = c_q;
    v_d   = v_q;
    if (exec) begin
      acc_d = alu_res;
      c_d   = alu_c;
      v_d   = alu_v;
    end
  end

  // State registers. Reset takes priority over ena and over the strobe.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_q <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      ps_q  <= 1'b0;
      z_q   <= 1'b1;
      n_q   <= 1'b0;
    end else if (ena) begin
      ps_q  <= strobe;
      acc_q <= acc_d;
      c_q   <= c_d;
      v_q   <= v_d;
      z_q   <= (acc_d == '0);
      n_q   <= acc_d[DATA_W-1];
    end
  end

  // Outputs come straight from registers
  always_comb begin
    uo_out  = acc_q;
    uio_out = {v_q, n_q, c_q, z_q, 4'b0000};
    uio_oe  = OE_MASK;
  end

endmodule

// File: tb/tb_tt_um_s_grundner.sv
// Directed testbench for tt_um_s_grundner: table of ALU vectors plus
// hand-written sequences for reset, held strobe, enable and reset priority.
module tb_tt_um_s_grundner;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] exp_acc;
    logic [7:0] exp_flags;
  } vec_t;

  vec_t vecs[19];

  tt_um_s_grundner dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n  = 1'b1;
    uio_in = 8'h00;
    for (int k = 0; k < cycles; k++) tick();
    rst_n = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Columns: op, B, expected ACC, expected flags {V,N,C,Z,0000}
    vecs[0]  = '{3'b000, 8'h7F, 8'h7F, 8'h00}; // LOAD 7F
    vecs[1]  = '{3'b001, 8'h01, 8'h80, 8'hC0}; // ADD 01 -> N,V
    vecs[2]  = '{3'b000, 8'h01, 8'h01, 8'h00}; // LOAD 01
    vecs[3]  = '{3'b001, 8'hFF, 8'h00, 8'h30}; // ADD FF -> Z,C
    vecs[4]  = '{3'b000, 8'h05, 8'h05, 8'h00}; // LOAD 05
    vecs[5]  = '{3'b010, 8'h06, 8'hFF, 8'h60}; // SUB 06 -> borrow,N
    vecs[6]  = '{3'b000, 8'h80, 8'h80, 8'h40}; // LOAD 80
    vecs[7]  = '{3'b010, 8'h01, 8'h7F, 8'h80}; // SUB 01 -> V
    vecs[8]  = '{3'b000, 8'hF0, 8'hF0, 8'h40}; // LOAD F0
    vecs[9]  = '{3'b011, 8'h3C, 8'h30, 8'h00}; // AND 3C
    vecs[10] = '{3'b100, 8'h0F, 8'h3F, 8'h00}; // OR 0F
    vecs[11] = '{3'b101, 8'h3F, 8'h00, 8'h10}; // XOR 3F -> Z
    vecs[12] = '{3'b000, 8'h81, 8'h81, 8'h40}; // LOAD 81
    vecs[13] = '{3'b110, 8'hAA, 8'h02, 8'h20}; // SHL -> C
    vecs[14] = '{3'b111, 8'h55, 8'h01, 8'h00}; // SHR
    vecs[15] = '{3'b111, 8'hFF, 8'h00, 8'h30}; // SHR -> Z,C
    vecs[16] = '{3'b000, 8'h80, 8'h80, 8'h40}; // LOAD 80
    vecs[17] = '{3'b001, 8'h80, 8'h00, 8'hB0}; // ADD 80 -> V,C,Z
    vecs[18] = '{3'b010, 8'h00, 8'h00, 8'h10}; // SUB 00 -> Z only

    // Reset for two cycles
    do_reset(2);
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h10);
    check("reset_oe", uio_oe, 8'hF0);

    // Table of single operations. The ignored upper nibble of uio_in varies.
    for (int i = 0; i < 19; i++) begin
      ui_in  = vecs[i].b;
      uio_in = {4'(i), 1'b1, vecs[i].op};
      tick();
      check($sformatf("vec%0d_acc", i), uo_out, vecs[i].exp_acc);
      check($sformatf("vec%0d_flags", i), uio_out, vecs[i].exp_flags);
      uio_in = {4'(i), 1'b0, 3'b000};
      ui_in  = 8'hEE;
      tick();
      check($sformatf("vec%0d_hold", i), uo_out, vecs[i].exp_acc);
    end

    // ADD 01 with the strobe held for 5 cycles; later opcode/B changes are ignored
    do_reset(1);
    ui_in  = 8'h01;
    uio_in = 8'h09;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("held%0d_acc", k), uo_out, 8'h01);
      ui_in  = 8'h55;
      uio_in = 8'h08; // LOAD with the strobe still high
    end
    uio_in = 8'h00;
    tick();
    check("held_release_acc", uo_out, 8'h01);
    check("held_release_flags", uio_out, 8'h00);

    // LOAD 81, then SHL
    ui_in = 8'h81; uio_in = 8'h08; tick();
    uio_in = 8'h00; tick();
    ui_in = 8'h00; uio_in = 8'h0E; tick();
    check("shl_acc", uo_out, 8'h02);
    check("shl_flags", uio_out, 8'h20);
    uio_in = 8'h00; tick();

    // ena=0 while strobing ADD 10: nothing changes
    ena = 1'b0;
    ui_in = 8'h10; uio_in = 8'h09;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ena0_%0d_acc", k), uo_out, 8'h02);
    end
    uio_in = 8'h00; tick();
    ena = 1'b1; tick();
    check("ena_back_acc", uo_out, 8'h02);
    check("ena_back_flags", uio_out, 8'h20);

    // Reset on the same edge as an execute strobe: the reset wins
    rst_n = 1'b1; ui_in = 8'h10; uio_in = 8'h09;
    tick();
    check("rst_strobe_uo", uo_out, 8'h00);
    check("rst_strobe_uio", uio_out, 8'h10);
    // Strobe still high at release: one execution on the first non-reset edge
    rst_n = 1'b0;
    tick();
    check("post_rst_exec", uo_out, 8'h10);
    tick();
    check("post_rst_once", uo_out, 8'h10);
    uio_in = 8'h00; tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
